// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MD opcodes and FSM states.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mfhi  = 4'd5,
    MDU_mflo  = 4'd6,
    MDU_mthi  = 4'd7,
    MDU_mtlo  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// HI/LO owning multiply/divide unit; fixed busy window, commit at the last busy edge.
// No backpressure: starts while busy are dropped, the hazard unit stalls on busy|start.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic        start,
  output logic        busy,
  output logic [31:0] out
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0]       op_q, op_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, uq, ur, sq, sr;

  assign start = (op == MDU_mult || op == MDU_multu || op == MDU_div || op == MDU_divu)
                 && (state_q == MDU_IDLE);
  assign busy  = (state_q == MDU_BUSY);

  always_comb begin
    out = 32'd0;
    case (op)
      MDU_mfhi: out = hi_q;
      MDU_mflo: out = lo_q;
      default:  out = 32'd0;
    endcase
  end

  // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_neg  = a_q[31] && (op_q == MDU_div);
    b_neg  = b_q[31] && (op_q == MDU_div);
    mag_a  = a_neg ? (32'd0 - a_q) : a_q;
    mag_b  = b_neg ? (32'd0 - b_q) : b_q;
    uq     = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    ur     = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    sq     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    sr     = a_neg ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = (op == MDU_div || op == MDU_divu) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = MDU_BUSY;
        end else if (op == MDU_mthi) begin
          hi_d = a;
        end else if (op == MDU_mtlo) begin
          lo_d = a;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MDU_IDLE;
          case (op_q)
            MDU_mult:  {hi_d, lo_d} = prod_s;
            MDU_multu: {hi_d, lo_d} = prod_u;
            MDU_div, MDU_divu: begin
              if (b_q != 32'd0) begin
                hi_d = sr;
                lo_d = sq;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table of MD ops plus hand sequences for busy-window corners.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_r, b_r;
  logic [3:0]  op_r;
  logic        start, busy;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .a(a_r), .b(b_r), .op(op_r),
    .start(start), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int         cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    op_r = MDU_mfhi; #1;
    chk({nm, "_hi"}, out, hi);
    op_r = MDU_mflo; #1;
    chk({nm, "_lo"}, out, lo);
    op_r = MDU_none;
  endtask

  // Called ~1 time unit after a rising edge; returns number of busy cycles seen.
  task automatic do_op(input string nm, input logic [3:0] o, input logic [31:0] av,
                       input logic [31:0] bv, output int n);
    op_r = o; a_r = av; b_r = bv; #1;
    chk({nm, "_start"}, {31'd0, start}, 32'd1);
    @(posedge clk); #1;
    op_r = MDU_none; a_r = 32'hA5A5A5A5; b_r = 32'h5A5A5A5A;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{"mult_neg",  MDU_mult,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"multu_max", MDU_multu, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"div_neg",   MDU_div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu_zero", MDU_divu,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{"div_ovf",   MDU_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{"divu_big",  MDU_divu,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[6] = '{"div_negb",  MDU_div,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{"mult_pos",  MDU_mult,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};

    reset = 1'b1; op_r = MDU_none; a_r = 32'd0; b_r = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_out", out, 32'd0);
    rd("rst", 32'd0, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk({vecs[i].nm, "_cyc"}, n, vecs[i].cyc);
      rd(vecs[i].nm, vecs[i].hi, vecs[i].lo);
      @(posedge clk); #1;
    end

    // mthi in IDLE, LO must keep the last multiply result
    op_r = MDU_mthi; a_r = 32'hDEADBEEF;
    @(posedge clk); #1;
    op_r = MDU_none;
    rd("mthi", 32'hDEADBEEF, vecs[7].lo);

    // mult 3*4 with a div and an mtlo offered during the busy window
    op_r = MDU_mult; a_r = 32'd3; b_r = 32'd4;
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 100) begin
      if (n == 0) begin
        op_r = MDU_div; a_r = 32'd100; b_r = 32'd5; #1;
        chk("busy_start", {31'd0, start}, 32'd0);
      end else if (n == 1) begin
        op_r = MDU_mtlo; a_r = 32'h1234;
      end else begin
        op_r = MDU_none;
      end
      n++;
      @(posedge clk); #1;
    end
    op_r = MDU_none;
    chk("ign_cyc", n, 32'd5);
    rd("ign", 32'd0, 32'd12);

    // back-to-back divides, second issued the cycle busy drops
    do_op("b2b1", MDU_div, 32'd100, 32'd7, n);
    chk("b2b1_cyc", n, 32'd10);
    rd("b2b1", 32'd2, 32'd14);
    op_r = MDU_div; a_r = 32'd50; b_r = 32'd6; #1;
    chk("b2b2_start", {31'd0, start}, 32'd1);
    @(posedge clk); #1;
    chk("b2b2_busy", {31'd0, busy}, 32'd1);
    op_r = MDU_none;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("b2b2_cyc", n, 32'd10);
    rd("b2b2", 32'd2, 32'd8);

    // reset during the 4th busy cycle of a divide
    op_r = MDU_div; a_r = 32'd1000; b_r = 32'd3;
    @(posedge clk); #1;
    op_r = MDU_none;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    rd("rstmid", 32'd0, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("rstlate_busy", {31'd0, busy}, 32'd0);
    rd("rstlate", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the execute stage of the pipelined MIPS core, sitting beside the ALU and owning the HI/LO register pair. It accepts one operation per accepted start, sequences it through a fixed-latency busy window, and commits HI/LO at the end. It also exports `busy`/`start` so the hazard unit can stall later multiply/divide instructions.

## Interface
- `MULT_CYCLES`, 5, busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, 10, busy cycles for `div`/`divu`; must be ≥ 1.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  reset; one clock, synchronous, active-high.
- `a`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- `b`  in  32  rt operand (divisor / multiplier).
- `op`  in  4  `MDU_*` code: none, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- `start`  out  1  combinational; 1 when `op` is mult/multu/div/divu and `busy`=0.
- `busy`  out  1  registered; 1 while an operation is in flight.
- `out`  out  32  combinational; HI for mfhi, LO for mflo, else 0.

## Operation
- FSM has two states, reset state IDLE:
  - IDLE: if `start`, latch a, b and op, load `cnt` with the latency, go to BUSY.
  - BUSY: decrement `cnt` each cycle. When `cnt`=1, write HI/LO and return to IDLE.
- `busy` = (state==BUSY).
- Arithmetic is computed from the latched operands, never the live `a`/`b`:
  - mult: {HI,LO} = signed 64-bit a×b.
  - multu: {HI,LO} = unsigned 64-bit a×b.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor = 0 (div or divu): HI/LO unchanged; busy window still runs its full length.
- mthi/mtlo:
  - In IDLE, write `a` to HI/LO at the clock edge.
  - In BUSY, ignored.
- A start op presented while busy is ignored; the hazard unit guarantees it never happens.
- mfhi/mflo read HI/LO combinationally. While BUSY they return the old values; preventing that read is the hazard unit's job.
- Reset:
  - HI=LO=0, state=IDLE, `cnt`=0.
  - Any in-flight operation is discarded with no HI/LO write.

## Timing
- Reset values: `busy`=0, `out`=0 when op=none, HI=LO=0.
- Start accepted at edge E0: `busy`=1 from E0 through E_N, where N = latency. HI/LO are updated at edge E_N. `busy`=0 after E_N.
  - mult: `busy` high for exactly 5 cycles.
  - div: `busy` high for exactly 10 cycles.
- In the cycle `busy` falls (after E_N), a new start is accepted at the next edge; there are no bubble cycles. mfhi issued in that cycle sees the new HI.
- `start` and `out` are combinational from `op` and state and add no latency. mthi/mtlo take effect at the next edge.
- Reset is synchronous: asserting it during BUSY clears `busy` at that same edge.

## Structure
- Add to const.v, alongside the `ALU_*` codes:
  - `MDU_none`, `MDU_mult`, `MDU_multu`, `MDU_div`, `MDU_divu`, `MDU_mfhi`, `MDU_mflo`, `MDU_mthi`, `MDU_mtlo` (4-bit).
  - MDU state encodings.
- Single module with inline arithmetic; no sub-module.
- The hazard unit consumes `busy|start` together with a decoded "is MD instruction in D" signal.

## Test plan
- mult a=0xFFFFFFFE (−2), b=3 → busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; mfhi returns 0x00000001.
- div a=−7, b=2 → busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu 7/0 → HI/LO unchanged after 10 cycles.
- Back-to-back:
  - mult, then div presented while busy → div ignored.
  - div reissued in the cycle busy drops → accepted; busy stays 0 for at most zero cycles.
  - mtlo 0x1234 during BUSY → ignored.
- Reset mid-div at cycle 4 → busy=0 at that edge; HI=LO=0; no later write.
- mthi 0xDEADBEEF in IDLE, then mfhi → 0xDEADBEEF; mflo → previous LO.
